// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_pkg.sv - shared types and helpers for the clock-enable sequencer
// Helpers work on MAX_DOM-wide vectors; callers zero-extend and truncate to N_DOM.
package gf180mcu_fd_sc_mcu7t5v0__clken_seq_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int MAX_DOM = 16;

  function automatic int tmr_w(input int stagger);
    return $clog2(stagger + 1);
  endfunction

  function automatic int idx_w(input int n_dom);
    return (n_dom > 1) ? $clog2(n_dom) : 1;
  endfunction

  // One-hot of the lowest latched branch that is not yet enabled, or zero.
  function automatic logic [MAX_DOM-1:0] find_next_up(input logic [MAX_DOM-1:0] mlat,
                                                      input logic [MAX_DOM-1:0] en);
    logic [MAX_DOM-1:0] r;
    r = '0;
    for (int i = MAX_DOM - 1; i >= 0; i--) begin
      if (mlat[i] && !en[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // One-hot of the highest enabled branch, or zero.
  function automatic logic [MAX_DOM-1:0] find_next_down(input logic [MAX_DOM-1:0] en);
    logic [MAX_DOM-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DOM; i++) begin
      if (en[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_if.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_if.sv - request/enable handshake bundle of the sequencer
interface gf180mcu_fd_sc_mcu7t5v0__clken_seq_if #(
  parameter int N_DOM = 4
);
  logic             req;
  logic [N_DOM-1:0] mask;
  logic [N_DOM-1:0] en;
  logic             ack;
  logic             busy;

  modport master (output req, output mask, input en, input ack, input busy);
  modport slave  (input req, input mask, output en, output ack, output busy);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_tmr.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_tmr.sv - stagger down-counter with done pulse
// done is high in the cycle whose closing edge is STAGGER edges after the load edge.
module gf180mcu_fd_sc_mcu7t5v0__clken_seq_tmr
  import gf180mcu_fd_sc_mcu7t5v0__clken_seq_pkg::*;
#(
  parameter int STAGGER = 8
) (
  input  logic clk,
  input  logic rn,
  input  logic load,
  output logic done
);
  localparam int TW = tmr_w(STAGGER);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(STAGGER);
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done = (cnt == TW'(1));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv - staggered enable sequencer for AND-gated clock branches
// Enables rise lowest-first and fall highest-first, one bit per step, so EN stays a prefix of mlat.
module gf180mcu_fd_sc_mcu7t5v0__clken_seq
  import gf180mcu_fd_sc_mcu7t5v0__clken_seq_pkg::*;
#(
  parameter int N_DOM   = 4,
  parameter int STAGGER = 8
) (
  input  logic clk,
  input  logic rn,
  gf180mcu_fd_sc_mcu7t5v0__clken_seq_if.slave bus,
  inout  wire  vdd,
  inout  wire  vss
);
  state_t           state;
  logic [N_DOM-1:0] en_q;
  logic [N_DOM-1:0] mlat;
  logic             ack_q;
  logic             busy_q;
  logic             tmr_load;
  logic             tmr_done;
  logic [N_DOM-1:0] up_first;
  logic [N_DOM-1:0] up_nxt;
  logic [N_DOM-1:0] dn_nxt;

  wire unused_supply = vdd ^ vss;

  assign up_first = N_DOM'(find_next_up(MAX_DOM'(bus.mask), '0));
  assign up_nxt   = N_DOM'(find_next_up(MAX_DOM'(mlat), MAX_DOM'(en_q)));
  assign dn_nxt   = N_DOM'(find_next_down(MAX_DOM'(en_q)));

  // Every EN step, and every direction change, restarts the stagger window.
  always_comb begin
    tmr_load = 1'b0;
    unique case (state)
      OFF:       tmr_load = bus.req;
      RAMP_UP:   tmr_load = !bus.req || (tmr_done && (|up_nxt));
      ON:        tmr_load = !bus.req;
      RAMP_DOWN: tmr_load = bus.req || (tmr_done && (|dn_nxt));
      default:   tmr_load = 1'b0;
    endcase
  end

  gf180mcu_fd_sc_mcu7t5v0__clken_seq_tmr #(
    .STAGGER (STAGGER)
  ) u_tmr (
    .clk  (clk),
    .rn   (rn),
    .load (tmr_load),
    .done (tmr_done)
  );

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state  <= OFF;
      en_q   <= '0;
      mlat   <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          if (bus.req) begin
            mlat   <= bus.mask;
            en_q   <= up_first;
            busy_q <= 1'b1;
            state  <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!bus.req) begin
            en_q  <= en_q & ~dn_nxt;
            state <= RAMP_DOWN;
          end else if (tmr_done) begin
            if (|up_nxt) begin
              en_q <= en_q | up_nxt;
            end else begin
              ack_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= ON;
            end
          end
        end
        ON: begin
          if (!bus.req) begin
            en_q   <= en_q & ~dn_nxt;
            busy_q <= 1'b1;
            state  <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (bus.req) begin
            en_q  <= en_q | up_nxt;
            state <= RAMP_UP;
          end else if (tmr_done) begin
            if (|dn_nxt) begin
              en_q <= en_q & ~dn_nxt;
            end else begin
              ack_q  <= 1'b0;
              busy_q <= 1'b0;
              state  <= OFF;
            end
          end
        end
        default: state <= OFF;
      endcase
    end
  end

  assign bus.en   = en_q;
  assign bus.ack  = ack_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv - self-checking bench for the clock-enable sequencer
module tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq;
  localparam int N = 4;
  localparam int S = 3;
  localparam int M_OFF  = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DOWN = 3;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__clken_seq_if #(.N_DOM(N)) bus ();

  gf180mcu_fd_sc_mcu7t5v0__clken_seq #(
    .N_DOM   (N),
    .STAGGER (S)
  ) dut (
    .clk (clk),
    .rn  (rn),
    .bus (bus),
    .vdd (vdd),
    .vss (vss)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: ordered list of participating branches and how many of them are on.
  int          m_mode;
  int          bits[$];
  int          k;
  longint      t;
  longint      nxt;
  logic        m_ack;
  logic [N-1:0] m_mlat;
  logic [N-1:0] en_prev;

  typedef struct {
    logic         req;
    logic [N-1:0] mask;
    int           n;
    logic [N-1:0] en;
    logic         ack;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_en();
    logic [N-1:0] v = '0;
    for (int i = 0; i < k; i++) v[bits[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_OFF;
    bits.delete();
    k      = 0;
    t      = 0;
    nxt    = 0;
    m_ack  = 1'b0;
    m_mlat = '0;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] mk);
    t++;
    case (m_mode)
      M_OFF: if (r) begin
        m_mlat = mk;
        bits.delete();
        for (int i = 0; i < N; i++) if (mk[i]) bits.push_back(i);
        k      = (bits.size() > 0) ? 1 : 0;
        m_mode = M_UP;
        nxt    = t + S;
      end
      M_ON: if (!r) begin
        k      = (k > 0) ? k - 1 : 0;
        m_mode = M_DOWN;
        nxt    = t + S;
      end
      M_UP: begin
        if (!r) begin
          k      = (k > 0) ? k - 1 : 0;
          m_mode = M_DOWN;
          nxt    = t + S;
        end else if (t == nxt) begin
          if (k < bits.size()) begin
            k++;
            nxt = t + S;
          end else begin
            m_mode = M_ON;
            m_ack  = 1'b1;
          end
        end
      end
      default: begin
        if (r) begin
          k      = (k < bits.size()) ? k + 1 : k;
          m_mode = M_UP;
          nxt    = t + S;
        end else if (t == nxt) begin
          if (k > 0) begin
            k--;
            nxt = t + S;
          end else begin
            m_mode = M_OFF;
            m_ack  = 1'b0;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    logic         r;
    logic [N-1:0] mk;
    r  = bus.req;
    mk = bus.mask;
    @(posedge clk);
    model_step(r, mk);
    #1;
    check("model_en", bus.en, model_en());
    check("model_ack", bus.ack, m_ack);
    check("model_busy", bus.busy, (m_mode == M_UP || m_mode == M_DOWN));
    check("en_one_step", ($countones(bus.en ^ en_prev) <= 1), 1'b1);
    check("en_subset", ((bus.en & ~m_mlat) == '0), 1'b1);
    en_prev = bus.en;
  endtask

  task automatic do_reset();
    rn       = 1'b0;
    bus.req  = 1'b0;
    bus.mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", bus.en, '0);
    check("reset_ack", bus.ack, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rn      = 1'b1;
    en_prev = '0;
  endtask

  task automatic add(input logic r, input logic [N-1:0] mk, input int n,
                     input logic [N-1:0] en, input logic ack, input logic busy);
    vec_t v;
    v.req = r; v.mask = mk; v.n = n; v.en = en; v.ack = ack; v.busy = busy;
    tbl.push_back(v);
  endtask

  initial begin
    bus.req  = 1'b0;
    bus.mask = '0;
    en_prev  = '0;
    model_reset();

    // Full mask ramp up, hold, ramp down.
    add(1, 4'b1111, 1, 4'b0001, 0, 1);
    add(1, 4'b1111, 3, 4'b0011, 0, 1);
    add(1, 4'b1111, 3, 4'b0111, 0, 1);
    add(1, 4'b1111, 3, 4'b1111, 0, 1);
    add(1, 4'b1111, 2, 4'b1111, 0, 1);
    add(1, 4'b1111, 1, 4'b1111, 1, 0);
    add(1, 4'b1111, 6, 4'b1111, 1, 0);
    add(0, 4'b1111, 1, 4'b0111, 1, 1);
    add(0, 4'b1111, 3, 4'b0011, 1, 1);
    add(0, 4'b1111, 3, 4'b0001, 1, 1);
    add(0, 4'b1111, 3, 4'b0000, 1, 1);
    add(0, 4'b1111, 2, 4'b0000, 1, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    // Sparse mask, MASK wiggled mid-ramp must be ignored.
    add(1, 4'b1010, 1, 4'b0010, 0, 1);
    add(1, 4'b0101, 3, 4'b1010, 0, 1);
    add(1, 4'b0000, 3, 4'b1010, 1, 0);
    add(0, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 4'b1111, 3, 4'b0000, 1, 1);
    add(0, 4'b1111, 3, 4'b0000, 0, 0);
    // Reversal mid ramp-up: ACK never rises.
    add(1, 4'b1111, 1, 4'b0001, 0, 1);
    add(1, 4'b1111, 3, 4'b0011, 0, 1);
    add(1, 4'b1111, 1, 4'b0011, 0, 1);
    add(0, 4'b1111, 1, 4'b0001, 0, 1);
    add(0, 4'b1111, 3, 4'b0000, 0, 1);
    add(0, 4'b1111, 2, 4'b0000, 0, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 0);
    // All-masked request.
    add(1, 4'b0000, 1, 4'b0000, 0, 1);
    add(1, 4'b0000, 2, 4'b0000, 0, 1);
    add(1, 4'b0000, 1, 4'b0000, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1);
    add(0, 4'b0000, 3, 4'b0000, 0, 0);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      bus.req  = tbl[i].req;
      bus.mask = tbl[i].mask;
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d_en", i), bus.en, tbl[i].en);
      check($sformatf("vec%0d_ack", i), bus.ack, tbl[i].ack);
      check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].busy);
    end

    // Reversal inside the settle window after the last enable, then back up.
    bus.req  = 1'b1;
    bus.mask = 4'b1111;
    repeat (11) tick();
    check("settle_en_full", bus.en, 4'b1111);
    bus.req = 1'b0;
    tick();
    check("settle_rev_en", bus.en, 4'b0111);
    check("settle_rev_ack", bus.ack, 1'b0);
    bus.req = 1'b1;
    tick();
    check("settle_reup_en", bus.en, 4'b1111);
    repeat (3) tick();
    check("settle_on_ack", bus.ack, 1'b1);
    check("settle_on_busy", bus.busy, 1'b0);
    bus.req = 1'b0;
    tick();
    for (int c = 0; c < 40 && bus.busy; c++) tick();
    check("settle_off_busy", bus.busy, 1'b0);
    check("settle_off_ack", bus.ack, 1'b0);

    // Async reset mid ramp-down with ACK high: outputs clear without a clock edge.
    bus.req = 1'b1;
    repeat (13) tick();
    check("pre_rst_ack", bus.ack, 1'b1);
    bus.req = 1'b0;
    repeat (4) tick();
    check("pre_rst_en", bus.en, 4'b0011);
    #2;
    rn = 1'b0;
    #1;
    check("async_rst_en", bus.en, '0);
    check("async_rst_ack", bus.ack, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    model_reset();
    en_prev = '0;
    @(posedge clk);
    #1;
    rn = 1'b1;

    // Random request/mask traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) bus.req = ~bus.req;
      bus.mask = N'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
